// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_pkg : shared pipeline constants for the fetch stage    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam int unsigned c_XLEN      = 64;
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WAIT  = 2'd1;
  localparam logic [1:0] c_ST_HOLD  = 2'd2;
  localparam logic [1:0] c_ST_DRAIN = 2'd3;

  function automatic logic [4:0] f_rs1(input logic [31:0] instr);
    f_rs1 = instr[19:15];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] instr);
    f_rs2 = instr[24:20];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_if : instruction-memory request/response channel       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fetch_stage_if import fetch_stage_pkg::*; #(
  parameter int unsigned XLEN = c_XLEN
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);

endinterface
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_ifid_reg : IF/ID pipeline register, flush > hold > load |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_stage_ifid_reg import fetch_stage_pkg::*; #(
  parameter int unsigned XLEN      = c_XLEN,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            flush_i,
  input  wire logic            hold_i,
  input  wire logic            load_i,
  input  wire logic [XLEN-1:0] pc_i,
  input  wire logic [31:0]     instr_i,
  output logic                 valid_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [31:0]          instr_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  // A bubble keeps the last pc so downstream debug still sees where we were.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!hold_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        pc_d    = pc_i;
        instr_d = instr_i;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign rs1_o   = f_rs1(instr_q);
  assign rs2_o   = f_rs2(instr_q);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : PC sequencing, imem handshake, skid buffer, IF/ID    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_stage import fetch_stage_pkg::*; #(
  parameter int unsigned      XLEN      = c_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = c_NOP_INSTR
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            stall_i,
  input  wire logic            redirect_i,
  input  wire logic [XLEN-1:0] redirect_pc_i,
  fetch_stage_if.master        imem,
  output logic                 ifid_valid_o,
  output logic [XLEN-1:0]      ifid_pc_o,
  output logic [31:0]          ifid_instr_o,
  output logic [4:0]           ifid_rs1_o,
  output logic [4:0]           ifid_rs2_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic            started_q;

  logic [XLEN-1:0] w_redirect_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_ifid_load;
  logic [XLEN-1:0] w_ifid_pc;
  logic [31:0]     w_ifid_instr;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
  assign w_pc_plus4    = pc_q + XLEN'(4);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    w_ifid_load  = 1'b0;
    w_ifid_pc    = pc_q;
    w_ifid_instr = imem.rdata;

    case (state_q)
      c_ST_IDLE: begin
        if (redirect_i) pc_d = w_redirect_pc;
        // Hold off one extra edge after reset release before requesting.
        if (started_q) state_d = c_ST_WAIT;
      end
      c_ST_WAIT: begin
        if (redirect_i) begin
          pc_d    = w_redirect_pc;
          state_d = imem.rvalid ? c_ST_WAIT : c_ST_DRAIN;
        end else if (imem.rvalid) begin
          pc_d = w_pc_plus4;
          if (stall_i) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = imem.rdata;
            state_d      = c_ST_HOLD;
          end else begin
            w_ifid_load = 1'b1;
          end
        end
      end
      c_ST_HOLD: begin
        if (redirect_i) begin
          pc_d    = w_redirect_pc;
          state_d = c_ST_WAIT;
        end else if (!stall_i) begin
          w_ifid_load  = skid_valid_q;
          w_ifid_pc    = skid_pc_q;
          w_ifid_instr = skid_instr_q;
          skid_valid_d = 1'b0;
          state_d      = c_ST_WAIT;
        end
      end
      c_ST_DRAIN: begin
        // The in-flight response belongs to the abandoned path; drop it.
        if (redirect_i) pc_d = w_redirect_pc;
        if (imem.rvalid) state_d = c_ST_WAIT;
      end
      default: state_d = c_ST_IDLE;
    endcase

    if (redirect_i) skid_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_ST_IDLE;
      pc_q         <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      started_q    <= 1'b1;
    end
  end

  assign imem.req  = (state_q == c_ST_WAIT);
  assign imem.addr = pc_q;

  fetch_stage_ifid_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .hold_i  (stall_i),
    .load_i  (w_ifid_load),
    .pc_i    (w_ifid_pc),
    .instr_i (w_ifid_instr),
    .valid_o (ifid_valid_o),
    .pc_o    (ifid_pc_o),
    .instr_o (ifid_instr_o),
    .rs1_o   (ifid_rs1_o),
    .rs2_o   (ifid_rs2_o)
  );

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath/PC width.
REQ-002 Parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 Parameter NOP_INSTR, default 32'h00000013, bubble encoding (addi x0,x0,0).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  from hazard detection unit; freezes IF/ID and PC advance.
REQ-007 redirect  in  1  taken branch/jump resolved in EX; flush and refetch.
REQ-008 redirect_pc  in  XLEN  redirect target, valid with redirect.
REQ-009 imem_req  out  1  instruction-memory request, level-held.
REQ-010 imem_addr  out  XLEN  request address, stable while imem_req high.
REQ-011 imem_rvalid  in  1  one-cycle response strobe, exactly one per request, latency >= 1 cycle.
REQ-012 imem_rdata  in  32  instruction, valid with imem_rvalid.
REQ-013 ifid_valid  out  1  IF/ID holds a real instruction.
REQ-014 ifid_pc  out  XLEN  PC of IF/ID instruction.
REQ-015 ifid_instr  out  32  IF/ID instruction.
REQ-016 ifid_rs1, ifid_rs2  out  5  ifid_instr[19:15], [24:20], fed to hazard unit; combinational from the IF/ID register.

Function
REQ-017 FSM states: IDLE, WAIT, HOLD, DRAIN; one outstanding request maximum.
REQ-018 IDLE: imem_req=0; next cycle -> WAIT (redirect in IDLE loads pc=redirect_pc first).
REQ-019 WAIT: imem_req=1, imem_addr=pc; on imem_rvalid with stall=0 -> IF/ID loads {1,pc,imem_rdata}, pc+=4, stay WAIT (new request next cycle, no bubble beyond memory latency).
REQ-020 WAIT, imem_rvalid with stall=1: response captured into one-entry skid buffer with its pc, pc+=4, -> HOLD; IF/ID unchanged.
REQ-021 HOLD: imem_req=0; when stall=0, IF/ID loads skid contents, -> WAIT.
REQ-022 WAIT without imem_rvalid and stall=0: IF/ID loads bubble (valid=0, NOP_INSTR, pc unchanged).
REQ-023 stall=1 and no redirect: IF/ID holds all fields, in every state.
REQ-024 redirect=1 has priority over stall and rvalid: IF/ID <- bubble; pc <- redirect_pc; skid cleared.
REQ-025 redirect in WAIT without same-cycle rvalid: -> DRAIN (req=0); the late response is discarded; on its imem_rvalid -> WAIT at redirect_pc.
REQ-026 redirect in WAIT with same-cycle rvalid, or in HOLD: response/skid discarded, -> WAIT at redirect_pc next cycle.
REQ-027 redirect in DRAIN: pc updated to new target, remain DRAIN until pending rvalid.
REQ-028 PC arithmetic modulo 2^XLEN; pc+4 wraps silently; redirect_pc[1:0] ignored (forced 0).

Reset
REQ-029 rst_n low asynchronously: state=IDLE, pc=RESET_PC, imem_req=0, skid empty, ifid_valid=0, ifid_pc=0, ifid_instr=NOP_INSTR.
REQ-030 rst_n low mid-WAIT abandons the request; responses in the first cycle after release are ignored (IDLE).
REQ-031 First imem_req rises the second rising edge after rst_n release.

Structure
REQ-032 NOP_INSTR, XLEN and the state enum belong in the shared pipeline package alongside other stage constants.
REQ-033 One sub-module natural: ifid_reg (IF/ID register with hold/flush controls); FSM, PC and skid stay in fetch_stage.

Verification
REQ-034 Reset release, 1-cycle memory, no stall -> imem_addr 0,4,8 on consecutive cycles; ifid_pc 0,4,8 with ifid_valid=1.
REQ-035 stall high 3 cycles while rvalid returns addr 8 -> IF/ID holds pc 4; HOLD entered; after stall drop ifid_pc=8, then fetch of 12.
REQ-036 redirect to 0x100 with 3-cycle memory mid-WAIT at 0x10 -> ifid_valid=0; response for 0x10 never reaches IF/ID; next imem_addr=0x100.
REQ-037 redirect and stall same cycle -> IF/ID bubble (valid=0, instr 0x00000013), pc=redirect_pc.
REQ-038 redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> fetch there, next imem_addr=0 (wrap).
REQ-039 rst_n pulsed low during WAIT -> outputs immediately at reset values; fetch restarts at RESET_PC.
